timer_bus_device: RTL



---
 rtl/timer_bus_if.sv | 23 ++
 rtl/timer_bus_device.sv | 124 ++++++++++++
 2 files changed

// File: rtl/timer_bus_if.sv
// CPU data-memory bus as seen by a memory-mapped responder.
// The CPU drives the address, strobes and store data; the device drives load data and the interrupt.
interface timer_bus_if #(
    parameter int unsigned DBITS = 32
);
    logic [DBITS-1:0] memAddrBus;
    logic             weBus;
    logic             reBus;
    logic [DBITS-1:0] dataBusIn;
    logic [DBITS-1:0] dataBusOut;
    logic             intr;
    logic [DBITS-1:0] intrId;

    modport master (
        output memAddrBus, weBus, reBus, dataBusIn,
        input  dataBusOut, intr, intrId
    );

    modport slave (
        input  memAddrBus, weBus, reBus, dataBusIn,
        output dataBusOut, intr, intrId
    );
endinterface

// File: rtl/timer_bus_device.sv
// Memory-mapped interval timer: TCNT/TLIM/TCTL registers, a prescaled tick,
// and a level interrupt raised when the count wraps at the limit.
module timer_bus_device #(
    parameter int unsigned       DBITS        = 32,
    parameter logic [DBITS-1:0]  BASE_ADDR    = 32'hF000_0020,
    parameter int unsigned       CLK_PER_TICK = 10000,
    parameter logic [DBITS-1:0]  DEVICE_ID    = 32'h1
) (
    input  logic        clk,
    input  logic        reset,
    timer_bus_if.slave  bus
);
    localparam int unsigned PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);

    localparam logic [DBITS-3:0] TCNT_WA = BASE_ADDR[DBITS-1:2];
    localparam logic [DBITS-3:0] TLIM_WA = TCNT_WA + 1'b1;
    localparam logic [DBITS-3:0] TCTL_WA = TCNT_WA + 2'd2;

    logic [DBITS-1:0] tcnt_q, tcnt_d;
    logic [DBITS-1:0] tlim_q, tlim_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             ready_q, ready_d;
    logic             ie_q, ie_d;
    logic             ovr_q, ovr_d;

    logic sel_cnt, sel_lim, sel_ctl;
    logic wr_cnt, wr_lim, wr_ctl;
    logic running, tick, match, hw_ready_set, ready_clr, ovr_clr;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.memAddrBus[1:0];

    assign sel_cnt = (bus.memAddrBus[DBITS-1:2] == TCNT_WA);
    assign sel_lim = (bus.memAddrBus[DBITS-1:2] == TLIM_WA);
    assign sel_ctl = (bus.memAddrBus[DBITS-1:2] == TCTL_WA);
    assign wr_cnt  = bus.weBus && sel_cnt;
    assign wr_lim  = bus.weBus && sel_lim;
    assign wr_ctl  = bus.weBus && sel_ctl;

    assign running      = (tlim_q != '0);
    assign tick         = running && (presc_q == PRESC_LAST);
    assign match        = tick && (tcnt_q == tlim_q - 1'b1);
    // A same-cycle TCNT store replaces the wrap, so it must not raise READY either.
    assign hw_ready_set = match && !wr_cnt;
    assign ready_clr    = wr_ctl && !bus.dataBusIn[0];
    assign ovr_clr      = wr_ctl && !bus.dataBusIn[2];

    always_comb begin
        presc_d = presc_q;
        tcnt_d  = tcnt_q;
        tlim_d  = tlim_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        ie_d    = ie_q;

        if (running) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            tcnt_d = match ? '0 : tcnt_q + 1'b1;
        end
        if (wr_cnt) begin
            tcnt_d  = bus.dataBusIn;
            presc_d = '0;
        end
        if (wr_lim) begin
            tlim_d  = bus.dataBusIn;
            tcnt_d  = '0;
            presc_d = '0;
        end

        if (wr_ctl) begin
            ie_d = bus.dataBusIn[1];
        end
        if (ready_clr) begin
            ready_d = 1'b0;
        end
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        // Hardware set beats a software clear; overrun only if READY survives this cycle.
        if (hw_ready_set) begin
            ready_d = 1'b1;
            if (ready_q && !ready_clr) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tcnt_q  <= '0;
            tlim_q  <= '0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            tlim_q  <= tlim_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

    always_comb begin
        bus.dataBusOut = '0;
        if (bus.reBus) begin
            if (sel_cnt) begin
                bus.dataBusOut = tcnt_q;
            end else if (sel_lim) begin
                bus.dataBusOut = tlim_q;
            end else if (sel_ctl) begin
                bus.dataBusOut = {{(DBITS-3){1'b0}}, ovr_q, ie_q, ready_q};
            end
        end
    end

    assign bus.intr   = ready_q && ie_q;
    assign bus.intrId = bus.intr ? DEVICE_ID : '0;
endmodule
